// File: rtl/branch_seq_pkg.sv
// Shared types and constants for the conditional-branch control sequencer.
package branch_seq_pkg;

  localparam logic [4:0] BR_OPCODE = 5'b10010;

  // Sequencer states; one cycle each except IDLE.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    COND = 3'd1,
    LDY  = 3'd2,
    ADD  = 3'd3,
    UPD  = 3'd4,
    DONE = 3'd5
  } state_e;

  // Condition codes carried in the low two bits of the C2 field.
  typedef enum logic [1:0] {
    ZR = 2'b00,
    NZ = 2'b01,
    PL = 2'b10,
    MI = 2'b11
  } cond_e;

  // Branch instruction word layout.
  typedef struct packed {
    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  c2;
    logic [18:0] c;
  } instr_t;

  // Registered control/status strobes, in output order.
  typedef struct packed {
    logic gra;
    logic rout;
    logic conin;
    logic pcout;
    logic yin;
    logic cout;
    logic alu_add;
    logic zin;
    logic zlowout;
    logic pcin;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  // True when the instruction word carries the branch opcode.
  function automatic logic is_branch(input logic [31:0] ir);
    instr_t i;
    i = instr_t'(ir);
    return (i.opcode == BR_OPCODE);
  endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Handshake, instruction and strobe bundle between the sequencer and its master.
interface branch_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [31:0]      ir;
  logic             con;
  logic [1:0]       c2_out;
  logic             Gra;
  logic             Rout;
  logic             CONin;
  logic             PCout;
  logic             Yin;
  logic             Cout;
  logic             alu_add;
  logic             Zin;
  logic             Zlowout;
  logic             PCin;
  logic             busy;
  logic             done;
  logic             taken;
  logic             err;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] ntaken_cnt;

  modport master (
    output start, ir, con,
    input  c2_out, Gra, Rout, CONin, PCout, Yin, Cout, alu_add, Zin,
           Zlowout, PCin, busy, done, taken, err, taken_cnt, ntaken_cnt
  );

  modport slave (
    input  start, ir, con,
    output c2_out, Gra, Rout, CONin, PCout, Yin, Cout, alu_add, Zin,
           Zlowout, PCin, busy, done, taken, err, taken_cnt, ntaken_cnt
  );
endinterface

// File: rtl/branch_seq_sat_counter.sv
// Saturating up-counter used for branch outcome statistics.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, stick at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_seq.sv
// Control sequencer for the conditional branch instruction (brzr/brnz/brpl/brmi).
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic       clock,
  input  logic       clear,
  branch_seq_if.slave bus
);

  state_e state;
  state_e state_n;
  instr_t ir_q;
  logic   taken_q;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_n;
  logic   inc_taken;
  logic   inc_ntaken;
  logic   unused_ir_fields;

  // Next state and the strobes for that state, registered below so outputs stay Moore.
  always_comb begin
    state_n = state;
    ctrl_n  = '0;

    unique case (state)
      IDLE: if (bus.start && is_branch(bus.ir)) state_n = COND;
      COND: state_n = LDY;
      LDY:  state_n = ADD;
      ADD:  state_n = UPD;
      UPD:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      COND: begin
        ctrl_n.gra   = 1'b1;
        ctrl_n.rout  = 1'b1;
        ctrl_n.conin = 1'b1;
      end
      LDY: begin
        ctrl_n.pcout = 1'b1;
        ctrl_n.yin   = 1'b1;
      end
      ADD: begin
        ctrl_n.cout    = 1'b1;
        ctrl_n.alu_add = 1'b1;
        ctrl_n.zin     = 1'b1;
      end
      UPD: begin
        // taken_q was settled at the end of LDY, so it is final by now.
        ctrl_n.zlowout = taken_q;
        ctrl_n.pcin    = taken_q;
      end
      DONE: ctrl_n.done = 1'b1;
      default: ;
    endcase

    ctrl_n.busy = (state_n != IDLE);
    ctrl_n.err  = (state == IDLE) && bus.start && !is_branch(bus.ir);
  end

  // State, instruction latch, outcome flag and output strobes.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      ir_q    <= '0;
      taken_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state  <= state_n;
      ctrl_q <= ctrl_n;
      if ((state == IDLE) && (state_n == COND)) begin
        ir_q <= instr_t'(bus.ir);
      end
      if (state == LDY) begin
        taken_q <= bus.con;
      end
    end
  end

  // Outcome counters advance during DONE only.
  assign inc_taken  = (state == DONE) &&  taken_q;
  assign inc_ntaken = (state == DONE) && !taken_q;

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (inc_taken),
    .count (bus.taken_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ntaken_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (inc_ntaken),
    .count (bus.ntaken_cnt)
  );

  // Remaining instruction fields are consumed by the datapath, not decoded here.
  assign unused_ir_fields = ^{ir_q.opcode, ir_q.ra, ir_q.c2[3:2], ir_q.c};

  assign bus.c2_out  = ir_q.c2[1:0];
  assign bus.Gra     = ctrl_q.gra;
  assign bus.Rout    = ctrl_q.rout;
  assign bus.CONin   = ctrl_q.conin;
  assign bus.PCout   = ctrl_q.pcout;
  assign bus.Yin     = ctrl_q.yin;
  assign bus.Cout    = ctrl_q.cout;
  assign bus.alu_add = ctrl_q.alu_add;
  assign bus.Zin     = ctrl_q.zin;
  assign bus.Zlowout = ctrl_q.zlowout;
  assign bus.PCin    = ctrl_q.pcin;
  assign bus.busy    = ctrl_q.busy;
  assign bus.done    = ctrl_q.done;
  assign bus.err     = ctrl_q.err;
  assign bus.taken   = taken_q;

endmodule

// File: tb/tb_branch_seq.sv
// Directed plus randomized bench for branch_seq, checking a 16-bit and a 2-bit counter build.
module tb_branch_seq;

  localparam logic [4:0] OP_BR = 5'b10010;

  logic clock = 1'b0;
  logic clear;

  int checks = 0;
  int errors = 0;

  // Reference model: uncapped outcome counts and the last accepted condition select.
  int unsigned m_taken  = 0;
  int unsigned m_ntaken = 0;
  logic [1:0]  m_c2     = 2'b00;
  logic        m_tk     = 1'b0;

  always #5 clock = ~clock;

  branch_seq_if #(.CNT_W(16)) bus16 ();
  branch_seq_if #(.CNT_W(2))  bus2 ();

  branch_seq #(.CNT_W(16)) dut16 (.clock(clock), .clear(clear), .bus(bus16.slave));
  branch_seq #(.CNT_W(2))  dut2  (.clock(clock), .clear(clear), .bus(bus2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // Strobe vector: Gra Rout CONin PCout Yin Cout alu_add Zin Zlowout PCin busy done err.
  function automatic logic [12:0] obs16();
    return {bus16.Gra, bus16.Rout, bus16.CONin, bus16.PCout, bus16.Yin, bus16.Cout,
            bus16.alu_add, bus16.Zin, bus16.Zlowout, bus16.PCin, bus16.busy, bus16.done, bus16.err};
  endfunction

  function automatic logic [12:0] obs2();
    return {bus2.Gra, bus2.Rout, bus2.CONin, bus2.PCout, bus2.Yin, bus2.Cout,
            bus2.alu_add, bus2.Zin, bus2.Zlowout, bus2.PCin, bus2.busy, bus2.done, bus2.err};
  endfunction

  // Expected strobes for cycle ph after acceptance (0 = idle).
  function automatic logic [12:0] exp_vec(input int ph, input logic tk);
    logic [12:0] e;
    e = '0;
    case (ph)
      1: e[12:10] = 3'b111;
      2: e[9:8]   = 2'b11;
      3: e[7:5]   = 3'b111;
      4: begin e[4] = tk; e[3] = tk; end
      5: e[1] = 1'b1;
      default: ;
    endcase
    if (ph >= 1 && ph <= 5) e[2] = 1'b1;
    return e;
  endfunction

  task automatic drive(input logic s, input logic [31:0] i, input logic c);
    bus16.start = s; bus16.ir = i; bus16.con = c;
    bus2.start  = s; bus2.ir  = i; bus2.con  = c;
  endtask

  task automatic chk_vec(input string tag, input logic [12:0] e);
    chk({tag, "_vec16"}, 32'(obs16()), 32'(e));
    chk({tag, "_vec2"},  32'(obs2()),  32'(e));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_tcnt16"}, 32'(bus16.taken_cnt),  sat(m_taken, 65535));
    chk({tag, "_ncnt16"}, 32'(bus16.ntaken_cnt), sat(m_ntaken, 65535));
    chk({tag, "_tcnt2"},  32'(bus2.taken_cnt),   sat(m_taken, 3));
    chk({tag, "_ncnt2"},  32'(bus2.ntaken_cnt),  sat(m_ntaken, 3));
  endtask

  task automatic chk_c2(input string tag, input logic [1:0] e);
    chk({tag, "_c2_16"}, 32'(bus16.c2_out), 32'(e));
    chk({tag, "_c2_2"},  32'(bus2.c2_out),  32'(e));
  endtask

  task automatic chk_tk(input string tag, input logic e);
    chk({tag, "_tk16"}, 32'(bus16.taken), 32'(e));
    chk({tag, "_tk2"},  32'(bus2.taken),  32'(e));
  endtask

  // Full branch transaction; called and returning at a falling edge in IDLE.
  task automatic run_branch(input string tag, input logic [31:0] ir, input logic c,
                            input int abort_ph, input bit restart, input logic [31:0] ir2);
    string t;
    drive(1'b1, ir, c);
    m_c2 = ir[20:19];
    for (int ph = 1; ph <= 6; ph++) begin
      @(negedge clock);
      t = $sformatf("%s_ph%0d", tag, ph);
      if (ph == 1) begin bus16.start = 1'b0; bus2.start = 1'b0; end
      if (ph >= 3) m_tk = c;
      chk_vec(t, exp_vec(ph, c));
      chk_c2(t, m_c2);
      if (ph >= 5) chk_tk(t, c);
      if (ph == 6) begin
        if (c) m_taken++; else m_ntaken++;
        chk_cnt(t);
      end
      if (restart && ph == 3) drive(1'b1, ir2, c);
      if (restart && ph == 4) begin bus16.start = 1'b0; bus2.start = 1'b0; end
      if (ph == abort_ph) begin
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        m_taken = 0; m_ntaken = 0; m_c2 = 2'b00; m_tk = 1'b0;
        t = {tag, "_abort"};
        chk_vec(t, '0);
        chk_c2(t, 2'b00);
        chk_tk(t, 1'b0);
        chk_cnt(t);
        @(negedge clock);
        chk_vec({t, "_after"}, '0);
        return;
      end
    end
  endtask

  // Non-branch opcode offered in IDLE: one err pulse, nothing else moves.
  task automatic run_err(input string tag, input logic [31:0] ir);
    drive(1'b1, ir, 1'($urandom));
    @(negedge clock);
    bus16.start = 1'b0; bus2.start = 1'b0;
    chk_vec({tag, "_pulse"}, 13'd1);
    chk_c2({tag, "_pulse"}, m_c2);
    @(negedge clock);
    chk_vec({tag, "_after"}, '0);
    chk_tk({tag, "_after"}, m_tk);
    chk_cnt({tag, "_after"});
  endtask

  initial begin
    logic [31:0] r;
    clear = 1'b1;
    drive(1'b1, 32'h9000_0010, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk_vec("reset", '0);
    chk_c2("reset", 2'b00);
    chk_tk("reset", 1'b0);
    chk_cnt("reset");
    clear = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    chk_vec("idle", '0);

    run_branch("brzr", 32'h9000_0010, 1'b1, 0, 1'b0, 32'h0);
    run_branch("brnz", 32'h9008_0010, 1'b0, 0, 1'b0, 32'h0);
    run_err("addop", 32'h1800_0000);
    run_branch("restart", 32'h9010_0000, 1'b1, 0, 1'b1, 32'h9018_0000);
    for (int k = 0; k < 3; k++) run_branch($sformatf("sat%0d", k), 32'h9000_0000, 1'b1, 0, 1'b0, 32'h0);
    chk("sat_tcnt2_is_3", 32'(bus2.taken_cnt), 32'd3);
    run_branch("abort_ldy", 32'h9000_0000, 1'b1, 2, 1'b0, 32'h0);

    for (int n = 0; n < 30; n++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[31:27] = OP_BR;
      if (r[31:27] == OP_BR)
        run_branch($sformatf("rnd%0d", n), r, 1'($urandom), 0, 1'($urandom_range(0, 1)), $urandom);
      else
        run_err($sformatf("rnderr%0d", n), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 Parameter CNT_W, default 16, width of the taken and not-taken statistics counters.
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 clear  in  1  reset; one clock, synchronous, active-high.
REQ-004 start  in  1  request to execute the instruction on ir; sampled only in IDLE.
REQ-005 ir  in  32  instruction: opcode [31:27], Ra [26:23], C2 [22:19], C [18:0].
REQ-006 con  in  1  registered CON flag from the datapath condition unit.
REQ-007 c2_out  out  2  condition select to the condition unit; equals ir_q[20:19].
REQ-008 Gra, Rout, CONin  out  1 each  select Ra onto the bus and latch CON.
REQ-009 PCout, Yin  out  1 each  PC to bus, bus to Y.
REQ-010 Cout, alu_add, Zin  out  1 each  sign-extended C to bus, ALU add, latch Z.
REQ-011 Zlowout, PCin  out  1 each  Z low to bus, bus to PC.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 taken  out  1  branch outcome; valid while done is high, held until the next accept.
REQ-015 err  out  1  one-cycle pulse when start arrives in IDLE with an opcode other than 10010.
REQ-016 taken_cnt, ntaken_cnt  out  CNT_W each  saturating outcome counters.

Function
REQ-017 FSM states: IDLE, COND, LDY, ADD, UPD, DONE.
REQ-018 In IDLE, start=1 with ir[31:27]=10010 captures ir into ir_q; next state is COND.
REQ-019 In IDLE, start=1 with any other opcode pulses err for one cycle; state stays IDLE.
REQ-020 start while busy is ignored; ir_q is not overwritten.
REQ-021 COND (1 cycle): Gra=Rout=CONin=1; next state LDY.
REQ-022 LDY (1 cycle): PCout=Yin=1; taken_q<=con at the end of the cycle; next state ADD.
REQ-023 ADD (1 cycle): Cout=alu_add=Zin=1; next state UPD.
REQ-024 UPD (1 cycle): Zlowout=PCin=taken_q; next state DONE.
REQ-025 DONE (1 cycle): done=1; the outcome counter selected by taken_q increments; next state IDLE.
REQ-026 Control outputs are Moore, decoded from state only; every strobe not listed for a state is 0.
REQ-027 c2_out is driven from ir_q in all states.
REQ-028 Latency from accepting start to the done pulse is exactly 5 cycles; a new start is accepted the cycle after DONE.
REQ-029 Counters saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-030 clear=1 at a rising edge forces IDLE, ir_q=0, taken_q=0 and both counters to 0; all outputs read 0 on the following cycle.
REQ-031 clear takes priority over start and over any in-flight state; an aborted branch neither pulses done nor increments a counter.

Structure
REQ-032 A shared package holds the BR_OPCODE constant (5'b10010), the state encoding, and the condition codes ZR=00, NZ=01, PL=10, MI=11.
REQ-033 One sub-module, sat_counter, implements the saturating counter (parameter CNT_W, inputs inc and clear); it is instantiated twice.

Verification
REQ-034 clear, then start with ir=0x9000_0010 (brzr) and con=1 in LDY -> c2_out=00; COND, LDY, ADD, UPD, DONE in order; PCin=Zlowout=1 in UPD; done and taken=1 at cycle 5; taken_cnt=1.
REQ-035 start with ir=0x9008_0010 (brnz) and con=0 -> c2_out=01; PCin=0 in UPD; taken=0; ntaken_cnt=1.
REQ-036 start with ir=0x1800_0000 (add opcode) -> err pulses for one cycle; busy stays 0; no strobes asserted.
REQ-037 Second start pulsed during ADD with a different ir -> ignored; c2_out unchanged; exactly one done.
REQ-038 clear asserted during LDY -> IDLE next cycle; all outputs 0; no done; counters 0.
REQ-039 With CNT_W=2, four taken branches -> taken_cnt saturates at 3 and does not wrap.
